popcnt_window_acc: RTL

Downstream consumer of the 9-input popcount adder stage. Accepts one popcount sample per cycle over a valid/ready handshake and accumulates samples over a fixed window of WINDOW samples. Emits the window total, the per-window peak sample and an error flag through a registered valid/ready output slot. Supports early window close via flush. Sits between the adder pipeline and the statistics/threshold logic.

---
 rtl/popcnt_window_acc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/popcnt_window_acc.sv
// popcnt_window_acc
//   Accumulates popcount samples over windows of WINDOW samples. Each closed
//   window produces a saturated total, the largest sample seen, the sample
//   count and an error flag. These are presented through a registered
//   valid/ready result slot. A flush pulse closes a partial window early.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid/in_ready    sample handshake; in_cnt is the sample value
//   flush                one-cycle pulse requesting an early window close
//   out_valid/out_ready  result slot handshake
//   out_sum              window total, saturated at 2^ACC_W-1
//   out_max              largest sample in the window
//   out_cnt              number of samples in the window
//   out_err              a sample exceeded MAX_CNT, or the total saturated
module popcnt_window_acc #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MAX_CNT = 9,
  parameter int unsigned WINDOW  = 16,
  parameter int unsigned ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_max,
  output logic [7:0]       out_cnt,
  output logic             out_err
);

  localparam int unsigned      SUM_W    = ACC_W + 1;
  localparam logic [7:0]       LAST_IDX = 8'(WINDOW - 1);
  localparam logic [7:0]       FULL_CNT = 8'(WINDOW);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CNT);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] peak;
  logic [7:0]       idx;
  logic             err;
  logic             flush_pend;

  logic             slot_free;
  logic             accept;
  logic             close;
  logic             close_req;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] peak_nxt;
  logic [7:0]       cnt_nxt;
  logic             err_nxt;
  logic             pend_nxt;

  assign slot_free = !out_valid || out_ready;
  // Only the sample that would complete the window must wait for the slot.
  assign in_ready  = !flush_pend && (slot_free || idx != LAST_IDX);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum_wide  = {1'b0, acc} + SUM_W'(in_cnt);
    acc_nxt   = acc;
    peak_nxt  = peak;
    cnt_nxt   = idx;
    err_nxt   = err;
    pend_nxt  = flush_pend;
    close_req = 1'b0;
    close     = 1'b0;

    if (accept) begin
      acc_nxt   = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      peak_nxt  = (in_cnt > peak) ? in_cnt : peak;
      err_nxt   = err | (in_cnt > MAX_C) | sum_wide[ACC_W];
      cnt_nxt   = idx + 8'd1;
      close_req = (cnt_nxt == FULL_CNT) || flush || flush_pend;
    end else begin
      close_req = flush_pend || (flush && idx != '0);
    end

    // A close that cannot reach a busy slot is parked as a pending flush.
    if (close_req) begin
      if (slot_free) begin
        close = 1'b1;
      end else begin
        pend_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      peak       <= '0;
      idx        <= '0;
      err        <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_max    <= '0;
      out_cnt    <= '0;
      out_err    <= 1'b0;
    end else if (close) begin
      out_valid  <= 1'b1;
      out_sum    <= acc_nxt;
      out_max    <= peak_nxt;
      out_cnt    <= cnt_nxt;
      out_err    <= err_nxt;
      acc        <= '0;
      peak       <= '0;
      idx        <= '0;
      err        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      peak       <= peak_nxt;
      idx        <= cnt_nxt;
      err        <= err_nxt;
      flush_pend <= pend_nxt;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
